// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle events into PULSE_LEN-cycle high pulses
// separated by at least GAP_LEN low cycles. Events that arrive while busy either
// retrigger the active pulse or wait in a bounded pending counter. An event that
// finds the counter full is dropped and reported on overflow.
// Handshake note: there is no backpressure. Every cycle with sig_in high is one
// event, and it is always consumed in that cycle: it starts a pulse, extends one,
// is queued, or is reported on overflow in the following cycle.
module pulse_stretcher #(
  parameter int PULSE_LEN  = 16,
  parameter int GAP_LEN    = 2,
  parameter int PEND_DEPTH = 4,
  localparam int PCNT_W    = $clog2(PEND_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              sig_in,
  input  logic              retrig_en,
  output logic              sig_out,
  output logic              busy,
  output logic [PCNT_W-1:0] pend_cnt,
  output logic              overflow
);

  // The down-counter holds (remaining cycles - 1) for both ACTIVE and GAP.
  localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0]  PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD   = CNT_W'(GAP_LEN - 1);
  localparam logic [PCNT_W-1:0] PEND_MAX   = PCNT_W'(PEND_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic q_req;    // this cycle's event has to go into the pending queue
  logic gap_end;  // last low cycle of GAP
  logic deq;      // GAP ends and another pulse starts straight away
  logic full;

  // Queue request / dequeue decode. An event on the GAP-exit cycle counts as
  // pending, so it starts the next pulse instead of being stranded in IDLE.
  always_comb begin
    q_req   = 1'b0;
    gap_end = 1'b0;
    deq     = 1'b0;
    full    = (pend_cnt == PEND_MAX);
    if (sig_in && ((state == ACTIVE && !retrig_en) || state == GAP)) begin
      q_req = 1'b1;
    end
    if (state == GAP && cnt == '0) begin
      gap_end = 1'b1;
    end
    if (gap_end && (pend_cnt != '0 || q_req)) begin
      deq = 1'b1;
    end
  end

  // Main FSM with its shared counter, pending queue and registered outputs.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state    <= IDLE;
      cnt      <= '0;
      sig_out  <= 1'b0;
      busy     <= 1'b0;
      pend_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      // A queue and a dequeue in the same cycle cancel, even when full.
      if (q_req && !deq) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          pend_cnt <= pend_cnt + PCNT_W'(1);
        end
      end else if (deq && !q_req) begin
        pend_cnt <= pend_cnt - PCNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (sig_in) begin
            state   <= ACTIVE;
            cnt     <= PULSE_LOAD;
            sig_out <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ACTIVE: begin
          if (sig_in && retrig_en) begin
            cnt <= PULSE_LOAD;
          end else if (cnt == '0) begin
            state   <= GAP;
            cnt     <= GAP_LOAD;
            sig_out <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (gap_end) begin
            if (deq) begin
              state   <= ACTIVE;
              cnt     <= PULSE_LOAD;
              sig_out <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          sig_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher. Instance a uses PULSE_LEN=4, GAP_LEN=2,
// PEND_DEPTH=2. Instance b uses PULSE_LEN=1, GAP_LEN=1, PEND_DEPTH=2.
// Cycle t is the clock period that starts at posedge t. Inputs for cycle t and
// the outputs seen in cycle t are both handled at the negedge inside that cycle.
module tb_pulse_stretcher;

  localparam int W = 5;  // {sig_out, busy, pend_cnt[1:0], overflow}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       sig_in_a, retrig_a, sig_out_a, busy_a, ovf_a;
  logic [1:0] pend_a;
  logic       sig_in_b, retrig_b, sig_out_b, busy_b, ovf_b;
  logic [1:0] pend_b;

  pulse_stretcher #(.PULSE_LEN(4), .GAP_LEN(2), .PEND_DEPTH(2)) dut_a (
    .clk       (clk),
    .RSTn      (rst_n),
    .sig_in    (sig_in_a),
    .retrig_en (retrig_a),
    .sig_out   (sig_out_a),
    .busy      (busy_a),
    .pend_cnt  (pend_a),
    .overflow  (ovf_a)
  );

  pulse_stretcher #(.PULSE_LEN(1), .GAP_LEN(1), .PEND_DEPTH(2)) dut_b (
    .clk       (clk),
    .RSTn      (rst_n),
    .sig_in    (sig_in_b),
    .retrig_en (retrig_b),
    .sig_out   (sig_out_b),
    .busy      (busy_b),
    .pend_cnt  (pend_b),
    .overflow  (ovf_b)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one event pattern and checks every cycle against hand-derived masks
  // (bit t of each mask is the value in cycle t). With pend_loose only an upper
  // bound of 1 is enforced on pend_cnt.
  task automatic run_case(input string name, input bit sel, input bit retrig, input int n,
                          input logic [31:0] ev, input logic [31:0] sig, input logic [31:0] bsy,
                          input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] ovf,
                          input bit pend_loose);
    logic [W-1:0] obs;
    logic [W-1:0] e;
    string        tag;
    if (sel) retrig_b = retrig; else retrig_a = retrig;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      if (sel) sig_in_b = ev[t]; else sig_in_a = ev[t];
      exp_q.push_back({sig[t], bsy[t], p1[t], p0[t], ovf[t]});
      obs = sel ? {sig_out_b, busy_b, pend_b, ovf_b} : {sig_out_a, busy_a, pend_a, ovf_a};
      e   = exp_q.pop_front();
      tag = $sformatf("%s c%0d", name, t);
      if (!pend_loose) begin
        check_val(tag, 8'(obs), 8'(e));
      end else begin
        check_val(tag, {5'd0, obs[4], obs[3], obs[0]}, {5'd0, e[4], e[3], e[0]});
        check_val({tag, " pend<=1"}, {7'd0, (obs[2:1] <= 2'd1)}, 8'd1);
      end
    end
    if (sel) sig_in_b = 1'b0; else sig_in_a = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    sig_in_a = 1'b0;
    retrig_a = 1'b0;
    sig_in_b = 1'b0;
    retrig_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset a", {3'd0, sig_out_a, busy_a, pend_a, ovf_a}, 8'd0);
    check_val("reset b", {3'd0, sig_out_b, busy_b, pend_b, ovf_b}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single event
    run_case("single", 0, 0, 9, 32'h1, 32'h1E, 32'h7E, 32'h0, 32'h0, 32'h0, 0);
    // two events, second queued
    run_case("queued", 0, 0, 14, 32'h5, 32'h79E, 32'h1FFE, 32'h78, 32'h0, 32'h0, 0);
    // retrigger mid-pulse
    run_case("retrig", 0, 1, 11, 32'h9, 32'hFE, 32'h3FE, 32'h0, 32'h0, 32'h0, 0);
    // retrigger on the last high cycle
    run_case("retrig_last", 0, 1, 12, 32'h11, 32'h1FE, 32'h7FE, 32'h0, 32'h0, 32'h0, 0);
    // queue fills, overflow, then full queue with an event on the GAP-exit cycle
    run_case("overflow", 0, 0, 26, 32'h4F, 32'h79E79E, 32'h1FFFFFE,
             32'h7E004, 32'h1FF8, 32'h10, 0);
    // events during GAP are queued even with retrig_en set
    run_case("gap_queue", 0, 1, 20, 32'h61, 32'h1E79E, 32'h7FFFE, 32'h1FC0, 32'h0, 32'h0, 0);

    // asynchronous reset mid-ACTIVE with one event pending
    run_case("pre_rst", 0, 0, 3, 32'h3, 32'h6, 32'h6, 32'h4, 32'h0, 32'h0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst sig_out", {7'd0, sig_out_a}, 8'd0);
    check_val("rst busy", {7'd0, busy_a}, 8'd0);
    check_val("rst pend_cnt", {6'd0, pend_a}, 8'd0);
    check_val("rst overflow", {7'd0, ovf_a}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_case("post_rst", 0, 0, 8, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
    run_case("post_rst_evt", 0, 0, 9, 32'h1, 32'h1E, 32'h7E, 32'h0, 32'h0, 32'h0, 0);

    // shortest settings, event every other cycle
    run_case("short", 1, 0, 10, 32'h55, 32'hAA, 32'h1FE, 32'h0, 32'h0, 32'h0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
